// File: rtl/lives_hud_renderer.sv
// Lives/invulnerability FSM plus the two-stage heart-row renderer for the HUD.
// Pixel coordinates in, heart ROM address out, registered ROM bit back out as hud_pixel.
module lives_hud_renderer #(
  parameter int MAX_LIVES     = 5,
  parameter int HEART_X0      = 8,
  parameter int HEART_Y0      = 8,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_HALF    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       new_game,
  output logic [3:0] heart_x,
  output logic [3:0] heart_y,
  output logic       heart_en,
  input  logic       heart_data,
  output logic       hud_pixel,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam logic [2:0]         MAX_L    = 3'(MAX_LIVES);
  localparam logic [7:0]         INV_LOAD = 8'(INVULN_FRAMES);
  localparam logic [3:0]         BLINK_H  = 4'(BLINK_HALF);
  localparam logic signed [10:0] X0       = 11'(HEART_X0);
  localparam logic signed [10:0] Y0       = 11'(HEART_Y0);

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  state_t     state, state_nx;
  logic [2:0] lives_nx;
  logic [7:0] inv_cnt, inv_cnt_nx;
  logic [3:0] blink_cnt, blink_cnt_nx, blink_inc;
  logic       blink_on, blink_on_nx;

  assign blink_inc = blink_cnt + 4'd1;
  assign game_over = (state == DEAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ALIVE;
      lives     <= MAX_L;
      inv_cnt   <= 8'd0;
      blink_cnt <= 4'd0;
      blink_on  <= 1'b1;
    end else begin
      state     <= state_nx;
      lives     <= lives_nx;
      inv_cnt   <= inv_cnt_nx;
      blink_cnt <= blink_cnt_nx;
      blink_on  <= blink_on_nx;
    end
  end

  // new_game overrides everything; a hit entering INVULN loads counters and masks a same-cycle frame_tick
  always_comb begin
    state_nx     = state;
    lives_nx     = lives;
    inv_cnt_nx   = inv_cnt;
    blink_cnt_nx = blink_cnt;
    blink_on_nx  = blink_on;
    if (new_game) begin
      state_nx     = ALIVE;
      lives_nx     = MAX_L;
      inv_cnt_nx   = 8'd0;
      blink_cnt_nx = 4'd0;
      blink_on_nx  = 1'b1;
    end else begin
      case (state)
        ALIVE: begin
          if (hit) begin
            if (lives > 3'd1) begin
              state_nx     = INVULN;
              lives_nx     = lives - 3'd1;
              inv_cnt_nx   = INV_LOAD;
              blink_cnt_nx = 4'd0;
              blink_on_nx  = 1'b1;
            end else begin
              state_nx = DEAD;
              lives_nx = 3'd0;
            end
          end
        end
        INVULN: begin
          if (frame_tick) begin
            inv_cnt_nx = inv_cnt - 8'd1;
            if (blink_inc == BLINK_H) begin
              blink_cnt_nx = 4'd0;
              blink_on_nx  = ~blink_on;
            end else begin
              blink_cnt_nx = blink_inc;
            end
            if (inv_cnt == 8'd1) state_nx = ALIVE;
          end
        end
        DEAD: begin
          state_nx = DEAD;
        end
        default: state_nx = ALIVE;
      endcase
    end
  end

  logic signed [10:0] dx, dy;
  logic [6:0]         slot;
  logic               in_row, in_icon, show, draw;

  assign dx   = $signed({1'b0, pix_x}) - X0;
  assign dy   = $signed({1'b0, pix_y}) - Y0;
  assign slot = dx[10:4];

  // Column 15 of each 16-pixel pitch is the gap between hearts; the lost heart blinks only in INVULN
  assign in_row  = (dy[10:4] == 7'd0) && (dy[3:0] != 4'hF);
  assign in_icon = !dx[10] && (slot < {4'd0, MAX_L}) && (dx[3:0] != 4'hF);
  assign show    = (slot < {4'd0, lives}) ||
                   ((state == INVULN) && (slot == {4'd0, lives}) && blink_on);
  assign draw    = in_row && in_icon && show;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heart_en  <= 1'b0;
      heart_x   <= 4'd0;
      heart_y   <= 4'd0;
      hud_pixel <= 1'b0;
    end else begin
      heart_en  <= draw;
      heart_x   <= draw ? dx[3:0] : 4'd0;
      heart_y   <= draw ? dy[3:0] : 4'd0;
      hud_pixel <= heart_data;
    end
  end

endmodule

// File: tb/tb_lives_hud_renderer.sv
// Directed self-checking bench for lives_hud_renderer with a small stand-in heart ROM.
module tb_lives_hud_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       frame_tick, hit, new_game;
  logic [3:0] heart_x, heart_y;
  logic       heart_en, heart_data, hud_pixel;
  logic [2:0] lives;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in ROM: a checker-like pattern so hud_pixel carries both 0s and 1s
  assign heart_data = heart_en & (heart_x[0] ^ heart_y[0] ^ heart_x[2]);

  lives_hud_renderer dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .frame_tick(frame_tick), .hit(hit), .new_game(new_game),
    .heart_x(heart_x), .heart_y(heart_y), .heart_en(heart_en),
    .heart_data(heart_data), .hud_pixel(hud_pixel),
    .lives(lives), .game_over(game_over)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_hit(input logic with_tick);
    hit = 1'b1; frame_tick = with_tick;
    step();
    hit = 1'b0; frame_tick = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_x = '0; pix_y = '0;
    frame_tick = 1'b0; hit = 1'b0; new_game = 1'b0;
    step(); step();
    n_checks++; if (heart_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_heart_en got=%b exp=0", heart_en); end
    n_checks++; if (heart_x !== 4'd0 || heart_y !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_heart_xy got=%0d/%0d exp=0/0", heart_x, heart_y); end
    n_checks++; if (hud_pixel !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hud got=%b exp=0", hud_pixel); end
    n_checks++; if (lives !== 3'd5) begin n_fail++; $display("[TB] FAIL reset_lives got=%0d exp=5", lives); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_game_over got=%b exp=0", game_over); end
    rst_n = 1'b1;
    step();
  endtask

  // Scan pixels 0..99 on row y; hud_pixel for the previous pixel is checked one cycle behind heart_*
  task automatic test_row_scan(input int y, input int shown, input string tag);
    logic       exp_en, prev_en;
    logic [3:0] exp_col, exp_row, prev_col, prev_row;
    logic       exp_hud;
    prev_en = 1'b0; prev_col = 4'd0; prev_row = 4'd0;
    for (int x = 0; x < 100; x++) begin
      pix_x = 10'(x); pix_y = 10'(y);
      step();
      exp_en  = (y >= 8) && (y <= 22) && (x >= 8) && (x < 8 + 16 * shown) && (((x - 8) % 16) != 15);
      exp_col = exp_en ? 4'((x - 8) % 16) : 4'd0;
      exp_row = exp_en ? 4'(y - 8) : 4'd0;
      n_checks++;
      if (heart_en !== exp_en || heart_x !== exp_col || heart_y !== exp_row) begin
        n_fail++;
        $display("[TB] FAIL %s x=%0d got en=%b hx=%0d hy=%0d exp en=%b hx=%0d hy=%0d",
                 tag, x, heart_en, heart_x, heart_y, exp_en, exp_col, exp_row);
      end
      if (x > 0) begin
        exp_hud = prev_en & (prev_col[0] ^ prev_row[0] ^ prev_col[2]);
        n_checks++;
        if (hud_pixel !== exp_hud) begin
          n_fail++;
          $display("[TB] FAIL %s_hud x=%0d got=%b exp=%b", tag, x - 1, hud_pixel, exp_hud);
        end
      end
      prev_en = exp_en; prev_col = exp_col; prev_row = exp_row;
    end
    n_checks++; if (lives !== 3'(shown)) begin n_fail++; $display("[TB] FAIL %s_lives got=%0d exp=%0d", tag, lives, shown); end
  endtask

  task automatic test_boundaries();
    int         vx [10] = '{4, 23, 22, 8, 8, 8, 8, 88, 87, 86};
    int         vy [10] = '{10, 10, 10, 8, 22, 23, 7, 10, 10, 10};
    logic       ven[10] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    logic [3:0] vc [10] = '{0, 0, 14, 0, 0, 0, 0, 0, 0, 14};
    logic [3:0] vr [10] = '{0, 0, 2, 0, 14, 0, 0, 0, 0, 2};
    for (int i = 0; i < 10; i++) begin
      pix_x = 10'(vx[i]); pix_y = 10'(vy[i]);
      step();
      n_checks++;
      if (heart_en !== ven[i] || heart_x !== vc[i] || heart_y !== vr[i]) begin
        n_fail++;
        $display("[TB] FAIL boundary x=%0d y=%0d got en=%b hx=%0d hy=%0d exp en=%b hx=%0d hy=%0d",
                 vx[i], vy[i], heart_en, heart_x, heart_y, ven[i], vc[i], vr[i]);
      end
    end
  endtask

  // Watch the lost heart through a full invulnerability window; optionally fire a stray hit
  task automatic run_invuln(input int slot, input int stray_hit_at);
    logic exp_vis;
    pix_x = 10'(8 + 16 * slot + 5); pix_y = 10'd10;
    step();
    n_checks++; if (heart_en !== 1'b1) begin n_fail++; $display("[TB] FAIL blink_slot%0d_t0 got=%b exp=1", slot, heart_en); end
    for (int k = 1; k <= 60; k++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
      exp_vis = (k < 60) && (((k / 4) % 2) == 0);
      n_checks++;
      if (heart_en !== exp_vis) begin
        n_fail++;
        $display("[TB] FAIL blink_slot%0d tick=%0d got=%b exp=%b", slot, k, heart_en, exp_vis);
      end
      if (k == stray_hit_at) begin
        pulse_hit(1'b0);
        n_checks++;
        if (lives !== 3'(slot)) begin n_fail++; $display("[TB] FAIL invuln_hit_ignored got=%0d exp=%0d", lives, slot); end
      end
    end
    n_checks++; if (lives !== 3'(slot)) begin n_fail++; $display("[TB] FAIL invuln_end_lives got=%0d exp=%0d", lives, slot); end
  endtask

  task automatic test_hit_invuln();
    pulse_hit(1'b0);
    n_checks++; if (lives !== 3'd4) begin n_fail++; $display("[TB] FAIL first_hit_lives got=%0d exp=4", lives); end
    run_invuln(4, 10);
  endtask

  task automatic test_hit_with_tick();
    pulse_hit(1'b1);
    n_checks++; if (lives !== 3'd3) begin n_fail++; $display("[TB] FAIL hit_tick_lives got=%0d exp=3", lives); end
    run_invuln(3, -1);
  endtask

  task automatic test_to_dead();
    pulse_hit(1'b0); run_invuln(2, -1);
    pulse_hit(1'b0); run_invuln(1, -1);
    pulse_hit(1'b0);
    n_checks++; if (lives !== 3'd0 || game_over !== 1'b1) begin n_fail++; $display("[TB] FAIL dead got lives=%0d go=%b exp lives=0 go=1", lives, game_over); end
    test_row_scan(10, 0, "dead_scan");
    pulse_hit(1'b1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    n_checks++; if (lives !== 3'd0 || game_over !== 1'b1) begin n_fail++; $display("[TB] FAIL dead_hit_ignored got lives=%0d go=%b exp lives=0 go=1", lives, game_over); end
  endtask

  task automatic test_new_game_in_dead();
    new_game = 1'b1; hit = 1'b1;
    step();
    new_game = 1'b0; hit = 1'b0;
    n_checks++; if (lives !== 3'd5 || game_over !== 1'b0) begin n_fail++; $display("[TB] FAIL new_game got lives=%0d go=%b exp lives=5 go=0", lives, game_over); end
    step();
    pulse_hit(1'b0);
    n_checks++; if (lives !== 3'd4) begin n_fail++; $display("[TB] FAIL new_game_alive got=%0d exp=4", lives); end
    new_game = 1'b1; step(); new_game = 1'b0;
    n_checks++; if (lives !== 3'd5) begin n_fail++; $display("[TB] FAIL new_game_from_invuln got=%0d exp=5", lives); end
  endtask

  task automatic test_async_reset();
    pix_x = 10'd12; pix_y = 10'd10;
    pulse_hit(1'b0);
    step();
    n_checks++; if (heart_en !== 1'b1 || heart_x !== 4'd4 || heart_y !== 4'd2 || hud_pixel !== 1'b1) begin
      n_fail++; $display("[TB] FAIL pre_reset got en=%b hx=%0d hy=%0d hud=%b exp en=1 hx=4 hy=2 hud=1", heart_en, heart_x, heart_y, hud_pixel);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (heart_en !== 1'b0 || heart_x !== 4'd0 || heart_y !== 4'd0 || hud_pixel !== 1'b0) begin
      n_fail++; $display("[TB] FAIL async_reset_render got en=%b hx=%0d hy=%0d hud=%b exp all 0", heart_en, heart_x, heart_y, hud_pixel);
    end
    n_checks++; if (lives !== 3'd5 || game_over !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_state got lives=%0d go=%b exp lives=5 go=0", lives, game_over); end
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (heart_en !== 1'b1 || heart_x !== 4'd4) begin n_fail++; $display("[TB] FAIL post_reset_en got en=%b hx=%0d exp en=1 hx=4", heart_en, heart_x); end
    step();
    n_checks++; if (hud_pixel !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_hud got=%b exp=1", hud_pixel); end
  endtask

  initial begin
    test_reset();
    test_row_scan(10, 5, "scan_y10");
    test_boundaries();
    test_hit_invuln();
    test_hit_with_tick();
    test_to_dead();
    test_new_game_in_dead();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
